// File: rtl/core_sequencer.sv
// Instruction sequencer feeding the core/block-RAM pair: loadable program store,
// one 17-bit instruction per cycle, single-level hardware loop. Optional stall input
// is enabled with `define CORE_SEQUENCER_STALL_EN.
//
// state    | meaning
// ST_IDLE  | program store writable, NOP on output, waiting for start_i
// ST_RUN   | issuing store[pc] each cycle until halt or end of store
module core_sequencer #(
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 7,
  parameter int LOOP_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
`ifdef CORE_SEQUENCER_STALL_EN
  input  logic              stall_i,
`endif
  input  logic              prog_we_i,
  input  logic [ADDR_W-1:0] prog_addr_i,
  input  logic [19:0]       prog_data_i,
  input  logic              start_i,
  input  logic [LOOP_W-1:0] loop_count_i,
  output logic [16:0]       instruction_o,
  output logic              valid_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] pc_o
);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t              r_state;
  logic [19:0]         r_mem [DEPTH];
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   r_loop_start;
  logic [LOOP_W-1:0]   r_loop_rem;
  logic [16:0]         r_instr;
  logic                r_valid;
  logic                r_busy;
  logic                r_done;

  logic [19:0]         w_word;
  logic                w_halt;
  logic                w_loop_end;
  logic                w_loop_begin;
  logic                w_last;
  logic                w_stall;

`ifdef CORE_SEQUENCER_STALL_EN
  assign w_stall = stall_i;
`else
  assign w_stall = 1'b0;
`endif

  assign w_word       = r_mem[r_pc];
  assign w_halt       = w_word[19];
  assign w_loop_end   = w_word[18];
  assign w_loop_begin = w_word[17];
  assign w_last       = (r_pc == ADDR_W'(DEPTH - 1));

  // Store is deliberately not reset; writes are locked out while a program runs.
  always_ff @(posedge clk_i) begin
    if (prog_we_i && (r_state == ST_IDLE)) begin
      r_mem[prog_addr_i] <= prog_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state      <= ST_IDLE;
      r_pc         <= '0;
      r_loop_start <= '0;
      r_loop_rem   <= '0;
      r_instr      <= '0;
      r_valid      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_instr <= '0;
          r_valid <= 1'b0;
          // busy lags the state by one cycle, so it marks the cycle right after halt
          r_done  <= r_busy;
          r_busy  <= 1'b0;
          if (start_i) begin
            r_state      <= ST_RUN;
            r_busy       <= 1'b1;
            r_pc         <= '0;
            r_loop_rem   <= loop_count_i;
            r_loop_start <= '0;
          end
        end
        ST_RUN: begin
          r_done <= 1'b0;
          if (w_stall) begin
            r_instr <= '0;
            r_valid <= 1'b0;
          end else begin
            r_instr <= w_word[16:0];
            r_valid <= 1'b1;
            if (w_loop_begin) begin
              r_loop_start <= r_pc;
            end
            if (w_halt) begin
              r_state <= ST_IDLE;
            end else if (w_loop_end && (r_loop_rem != '0)) begin
              r_loop_rem <= r_loop_rem - LOOP_W'(1);
              r_pc       <= w_loop_begin ? r_pc : r_loop_start;
            end else if (w_last) begin
              r_state <= ST_IDLE;
            end else begin
              r_pc <= r_pc + ADDR_W'(1);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign instruction_o = r_instr;
  assign valid_o       = r_valid;
  assign busy_o        = r_busy;
  assign done_o        = r_done;
  assign pc_o          = r_pc;

endmodule
